// File: rtl/rmii_pkg.sv
// Shared constants and FSM state type for the RMII transmit dibit serializer.
package rmii_pkg;

  localparam int WORD_W  = 32;
  localparam int DIBIT_W = 2;
  localparam int DIBITS  = WORD_W / DIBIT_W;
  localparam int CNT_W   = $clog2(DIBITS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    UNDERRUN = 2'd2
  } tx_state_t;

endpackage

// File: rtl/word_hold_reg.sv
// One-entry holding register with full flag; a simultaneous load and take replaces the entry.
module word_hold_reg
  import rmii_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_dat,
  input  logic              load_last,
  input  logic              take,
  output logic              full,
  output logic [WORD_W-1:0] dat,
  output logic              last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      dat  <= '0;
      last <= 1'b0;
    end else begin
      if (load) begin
        full <= 1'b1;
        dat  <= load_dat;
        last <= load_last;
      end else if (take) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dibit_serialize.sv
// Serializes 32-bit words into 2-bit dibits (RMII TX), one per clk, gapless within a frame.
// Build option DIBIT_LSB_FIRST_EN selects LSB-first dibit order; default is MSB-first.
module dibit_serialize
  import rmii_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               axiiv,
  input  logic [WORD_W-1:0]  axiid,
  input  logic               axiil,
  output logic               axiir,
  output logic               axiov,
  output logic [DIBIT_W-1:0] axiod,
  output logic               axiol,
  output logic               underrun
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIBITS - 1);
  localparam logic [CNT_W-1:0] PENU_CNT = CNT_W'(DIBITS - 2);

`ifdef DIBIT_LSB_FIRST_EN
  function automatic logic [DIBIT_W-1:0] head(input logic [WORD_W-1:0] w);
    return w[DIBIT_W-1:0];
  endfunction
  function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w);
    return w >> DIBIT_W;
  endfunction
`else
  function automatic logic [DIBIT_W-1:0] head(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: DIBIT_W];
  endfunction
  function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w);
    return w << DIBIT_W;
  endfunction
`endif

  tx_state_t          state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [WORD_W-1:0]  act, act_nxt;
  logic               act_last, act_last_nxt;
  logic [DIBIT_W-1:0] dat_q, dat_nxt;
  logic               vld_q, vld_nxt;
  logic               lst_q, lst_nxt;
  logic               urun_q, urun_nxt;

  logic               pend_full, pend_last, pend_load, pend_take;
  logic [WORD_W-1:0]  pend_dat;
  logic               accept;
  logic               start;
  logic [WORD_W-1:0]  start_dat;
  logic               start_last;

  word_hold_reg u_pend (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pend_load),
    .load_dat  (axiid),
    .load_last (axiil),
    .take      (pend_take),
    .full      (pend_full),
    .dat       (pend_dat),
    .last      (pend_last)
  );

  assign axiir    = rst_n & ~pend_full;
  assign accept   = axiiv & axiir;
  assign axiov    = vld_q;
  assign axiod    = dat_q;
  assign axiol    = lst_q;
  assign underrun = urun_q;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    act_nxt      = act;
    act_last_nxt = act_last;
    dat_nxt      = dat_q;
    vld_nxt      = vld_q;
    lst_nxt      = 1'b0;
    urun_nxt     = urun_q;
    pend_load    = 1'b0;
    pend_take    = 1'b0;
    start        = 1'b0;
    start_dat    = axiid;
    start_last   = axiil;

    unique case (state)
      IDLE: begin
        vld_nxt = 1'b0;
        dat_nxt = '0;
        // A word parked during the previous frame's last dibit goes first.
        if (pend_full) begin
          pend_take  = 1'b1;
          start      = 1'b1;
          start_dat  = pend_dat;
          start_last = pend_last;
        end else if (accept) begin
          start = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt != LAST_CNT) begin
          dat_nxt   = head(act);
          act_nxt   = advance(act);
          cnt_nxt   = cnt + 1'b1;
          lst_nxt   = act_last && (cnt == PENU_CNT);
          pend_load = accept;
        end else if (!act_last && pend_full) begin
          pend_take  = 1'b1;
          start      = 1'b1;
          start_dat  = pend_dat;
          start_last = pend_last;
        end else if (!act_last && accept) begin
          // Word arriving on the final dibit bypasses the empty holding reg.
          start = 1'b1;
        end else if (act_last) begin
          state_nxt = IDLE;
          vld_nxt   = 1'b0;
          dat_nxt   = '0;
          cnt_nxt   = '0;
          pend_load = accept;
        end else begin
          state_nxt = UNDERRUN;
          vld_nxt   = 1'b0;
          dat_nxt   = '0;
          cnt_nxt   = '0;
          urun_nxt  = 1'b1;
        end
      end
      UNDERRUN: begin
        vld_nxt = 1'b0;
        dat_nxt = '0;
        if (accept && axiil) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (start) begin
      state_nxt    = SHIFT;
      cnt_nxt      = '0;
      dat_nxt      = head(start_dat);
      act_nxt      = advance(start_dat);
      act_last_nxt = start_last;
      vld_nxt      = 1'b1;
      lst_nxt      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      act      <= '0;
      act_last <= 1'b0;
      dat_q    <= '0;
      vld_q    <= 1'b0;
      lst_q    <= 1'b0;
      urun_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      act      <= act_nxt;
      act_last <= act_last_nxt;
      dat_q    <= dat_nxt;
      vld_q    <= vld_nxt;
      lst_q    <= lst_nxt;
      urun_q   <= urun_nxt;
    end
  end

endmodule

// File: tb/tb_dibit_serialize.sv
// Directed bench for dibit_serialize: table of single-word frames plus hand-written corner sequences.
module tb_dibit_serialize;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        axiiv = 1'b0;
  logic [31:0] axiid = '0;
  logic        axiil = 1'b0;
  logic        axiir;
  logic        axiov;
  logic [1:0]  axiod;
  logic        axiol;
  logic        underrun;

  int n_vec = 0;
  int n_err = 0;

  dibit_serialize dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .axiiv    (axiiv),
    .axiid    (axiid),
    .axiil    (axiil),
    .axiir    (axiir),
    .axiov    (axiov),
    .axiod    (axiod),
    .axiol    (axiol),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  // seq_* hold the expected dibit stream, first dibit in bits [31:30].
  typedef struct {
    logic [31:0] word;
    logic [31:0] seq_msb;
    logic [31:0] seq_lsb;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input logic [31:0] msb, input logic [31:0] lsb);
`ifdef DIBIT_LSB_FIRST_EN
    return lsb;
`else
    return msb;
`endif
  endfunction

  task automatic send(input logic [31:0] w, input logic l);
    int k;
    axiiv = 1'b1;
    axiid = w;
    axiil = l;
    k = 0;
    while (!axiir && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("send_ready_timeout", {31'd0, axiir}, 32'd1);
    @(posedge clk);
    #1 axiiv = 1'b0;
  endtask

  // Checks 16 dibits on consecutive negedges; at index drop_at the
  // second word must sit in the holding reg, then valid is withdrawn.
  task automatic check_stream(input logic [31:0] seq, input logic last, input int drop_at);
    logic [31:0] s;
    s = seq;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("axiov_d%0d", i), {31'd0, axiov}, 32'd1);
      check($sformatf("axiod_d%0d", i), {30'd0, axiod}, {30'd0, s[31-2*i -: 2]});
      check($sformatf("axiol_d%0d", i), {31'd0, axiol}, {31'd0, last && (i == 15)});
      if (i == drop_at) begin
        check("axiir_pend_full", {31'd0, axiir}, 32'd0);
        axiiv = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hFBBE7AB7};
    tbl[1] = '{32'h12345678, 32'h12345678, 32'h2D951C84};
    tbl[2] = '{32'h00000000, 32'h00000000, 32'h00000000};
    tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[4] = '{32'h0000000F, 32'h0000000F, 32'hF0000000};

    // Reset state
    #2;
    check("rst_axiov", {31'd0, axiov}, 32'd0);
    check("rst_axiod", {30'd0, axiod}, 32'd0);
    check("rst_axiol", {31'd0, axiol}, 32'd0);
    check("rst_axiir", {31'd0, axiir}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_axiir", {31'd0, axiir}, 32'd1);

    // Single-word frames
    for (int v = 0; v < 5; v++) begin
      send(tbl[v].word, 1'b1);
      check_stream(pick(tbl[v].seq_msb, tbl[v].seq_lsb), 1'b1, -1);
      @(negedge clk);
      check("tbl_axiov_after", {31'd0, axiov}, 32'd0);
      check("tbl_axiol_after", {31'd0, axiol}, 32'd0);
    end

    // Back-to-back words with valid held: 32 contiguous dibits
    @(negedge clk);
    axiiv = 1'b1;
    axiid = 32'h00000000;
    axiil = 1'b0;
    @(posedge clk);
    #1;
    axiid = 32'hFFFFFFFF;
    axiil = 1'b1;
    check_stream(32'h00000000, 1'b0, 1);
    check_stream(32'hFFFFFFFF, 1'b1, -1);
    @(negedge clk);
    check("b2b_axiov_after", {31'd0, axiov}, 32'd0);
    check("b2b_axiir_after", {31'd0, axiir}, 32'd1);

    // Two single-word frames queued: one idle cycle between them
    @(negedge clk);
    send(32'hDEADBEEF, 1'b1);
    axiiv = 1'b1;
    axiid = 32'h12345678;
    axiil = 1'b1;
    check_stream(pick(32'hDEADBEEF, 32'hFBBE7AB7), 1'b1, 1);
    @(negedge clk);
    check("ifg_gap_axiov", {31'd0, axiov}, 32'd0);
    check_stream(pick(32'h12345678, 32'h2D951C84), 1'b1, -1);
    @(negedge clk);
    check("ifg_axiov_after", {31'd0, axiov}, 32'd0);

    // Underrun: non-last word with nothing following
    @(negedge clk);
    send(32'h12345678, 1'b0);
    check_stream(pick(32'h12345678, 32'h2D951C84), 1'b0, -1);
    @(negedge clk);
    check("urun_axiov", {31'd0, axiov}, 32'd0);
    check("urun_flag", {31'd0, underrun}, 32'd1);
    repeat (5) @(negedge clk);
    check("urun_sticky", {31'd0, underrun}, 32'd1);
    send(32'hAAAAAAAA, 1'b1);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check("urun_discard_axiov", {31'd0, axiov}, 32'd0);
    end
    send(32'hDEADBEEF, 1'b1);
    check_stream(pick(32'hDEADBEEF, 32'hFBBE7AB7), 1'b1, -1);
    @(negedge clk);
    check("urun_still_set", {31'd0, underrun}, 32'd1);

    // Reset mid-word at dibit 7
    @(negedge clk);
    send(32'hDEADBEEF, 1'b1);
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("mid_axiov_before", {31'd0, axiov}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_axiov", {31'd0, axiov}, 32'd0);
    check("mid_rst_axiod", {30'd0, axiod}, 32'd0);
    check("mid_rst_axiir", {31'd0, axiir}, 32'd0);
    check("mid_rst_underrun", {31'd0, underrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_mid_rst_axiov", {31'd0, axiov}, 32'd0);
    end
    send(32'h12345678, 1'b1);
    check_stream(pick(32'h12345678, 32'h2D951C84), 1'b1, -1);
    @(negedge clk);
    check("final_axiov", {31'd0, axiov}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
